// File: rtl/sim_dmi_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sim_dmi_sequencer_if
//  Description : DMI request/response channel bundle between a DMI master
//                (the sequencer) and a debug module or bench responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sim_dmi_sequencer_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic                  debug_req_valid;
    logic                  debug_req_ready;
    logic [ADDR_WIDTH-1:0] debug_req_bits_addr;
    logic [1:0]            debug_req_bits_op;
    logic [DATA_WIDTH-1:0] debug_req_bits_data;
    logic                  debug_resp_valid;
    logic                  debug_resp_ready;
    logic [1:0]            debug_resp_bits_resp;
    logic [DATA_WIDTH-1:0] debug_resp_bits_data;

    modport master (
        output debug_req_valid,
        output debug_req_bits_addr,
        output debug_req_bits_op,
        output debug_req_bits_data,
        output debug_resp_ready,
        input  debug_req_ready,
        input  debug_resp_valid,
        input  debug_resp_bits_resp,
        input  debug_resp_bits_data
    );

    modport slave (
        input  debug_req_valid,
        input  debug_req_bits_addr,
        input  debug_req_bits_op,
        input  debug_req_bits_data,
        input  debug_resp_ready,
        output debug_req_ready,
        output debug_resp_valid,
        output debug_resp_bits_resp,
        output debug_resp_bits_data
    );
endinterface
`default_nettype wire

// File: rtl/sim_dmi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sim_dmi_sequencer
//  Description : Scripted DMI master. Replays a preloaded table of WRITE,
//                READ and POLL operations, retries busy responses, bounds
//                every handshake wait and reports pass/fail on 'exit'.
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_dmi_sequencer #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 32,
    parameter int SCRIPT_DEPTH   = 16,
    parameter int MAX_RETRIES    = 8,
    parameter int MAX_POLLS      = 256,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDXW          = (SCRIPT_DEPTH > 1) ? $clog2(SCRIPT_DEPTH) : 1
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   start,
    output logic                  busy,
    input  wire                   script_we,
    input  wire  [IDXW-1:0]       script_idx,
    input  wire  [1:0]            script_kind,
    input  wire  [ADDR_WIDTH-1:0] script_addr,
    input  wire  [DATA_WIDTH-1:0] script_data,
    input  wire  [DATA_WIDTH-1:0] script_mask,
    sim_dmi_sequencer_if.master   dmi,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [31:0]           exit
);

    localparam logic [1:0] c_KIND_WRITE = 2'd0;
    localparam logic [1:0] c_KIND_POLL  = 2'd2;
    localparam logic [1:0] c_KIND_END   = 2'd3;

    localparam logic [1:0] c_OP_READ    = 2'd1;
    localparam logic [1:0] c_OP_WRITE   = 2'd2;

    localparam logic [1:0] c_RESP_OK    = 2'd0;
    localparam logic [1:0] c_RESP_BUSY  = 2'd3;

    localparam logic [2:0] c_FAIL_RETRY   = 3'd2;
    localparam logic [2:0] c_FAIL_RESP    = 3'd3;
    localparam logic [2:0] c_FAIL_TIMEOUT = 3'd4;
    localparam logic [2:0] c_FAIL_POLL    = 3'd5;

    localparam int c_RETRY_W = $clog2(MAX_RETRIES + 2);
    localparam int c_POLL_W  = $clog2(MAX_POLLS + 2);
    localparam int c_TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRIES);
    localparam logic [c_POLL_W-1:0]  c_MAX_POLL  = c_POLL_W'(MAX_POLLS);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDXW-1:0]      c_LAST_IDX  = IDXW'(SCRIPT_DEPTH - 1);
    localparam logic [IDXW:0]        c_DEPTH     = (IDXW + 1)'(SCRIPT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                 r_state;
    logic [IDXW-1:0]        r_index;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_POLL_W-1:0]    r_poll;
    logic [c_TMO_W-1:0]     r_timeout;

    // Script table; deliberately not reset so a script survives a reset.
    logic [1:0]             r_mem_kind [SCRIPT_DEPTH];
    logic [ADDR_WIDTH-1:0]  r_mem_addr [SCRIPT_DEPTH];
    logic [DATA_WIDTH-1:0]  r_mem_data [SCRIPT_DEPTH];
    logic [DATA_WIDTH-1:0]  r_mem_mask [SCRIPT_DEPTH];

    logic                   w_ctrl_idle;
    logic [IDXW-1:0]        w_next_index;
    logic                   w_last_slot;
    logic [IDXW-1:0]        w_ld_index;
    logic [1:0]             w_ld_kind;
    logic [ADDR_WIDTH-1:0]  w_ld_addr;
    logic [DATA_WIDTH-1:0]  w_ld_data;
    logic [1:0]             w_ld_op;
    logic [DATA_WIDTH-1:0]  w_ld_wdata;
    logic [1:0]             w_cur_kind;
    logic [DATA_WIDTH-1:0]  w_cur_data;
    logic [DATA_WIDTH-1:0]  w_cur_mask;
    logic                   w_poll_miss;
    logic [c_RETRY_W-1:0]   w_retry_inc;
    logic [c_POLL_W-1:0]    w_poll_inc;
    logic                   w_tmo_expired;
    logic                   w_req_fire;
    logic                   w_resp_fire;

    function automatic logic [31:0] f_exit_fail(input logic [2:0] code);
        f_exit_fail = {28'd0, code, 1'b1};
    endfunction

    assign w_ctrl_idle  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_next_index = r_index + IDXW'(1);
    assign w_last_slot  = (r_index == c_LAST_IDX);

    // The load port fetches slot 0 when starting, otherwise the following slot.
    assign w_ld_index = (r_state == S_WAIT_RESP) ? w_next_index : '0;
    assign w_ld_kind  = r_mem_kind[w_ld_index];
    assign w_ld_addr  = r_mem_addr[w_ld_index];
    assign w_ld_data  = r_mem_data[w_ld_index];
    assign w_ld_op    = (w_ld_kind == c_KIND_WRITE) ? c_OP_WRITE : c_OP_READ;
    assign w_ld_wdata = (w_ld_kind == c_KIND_WRITE) ? w_ld_data : '0;

    // The current slot is stable while running since writes are blocked then.
    assign w_cur_kind  = r_mem_kind[r_index];
    assign w_cur_data  = r_mem_data[r_index];
    assign w_cur_mask  = r_mem_mask[r_index];
    assign w_poll_miss = (w_cur_kind == c_KIND_POLL) &&
                         ((dmi.debug_resp_bits_data & w_cur_mask) != (w_cur_data & w_cur_mask));

    assign w_retry_inc   = r_retry + c_RETRY_W'(1);
    assign w_poll_inc    = r_poll + c_POLL_W'(1);
    assign w_tmo_expired = (r_timeout == c_TMO_LAST);
    assign w_req_fire    = dmi.debug_req_valid && dmi.debug_req_ready;
    assign w_resp_fire   = dmi.debug_resp_valid && dmi.debug_resp_ready;

    // Script loading, accepted only while the sequencer is not executing.
    always_ff @(posedge clk) begin
        if (script_we && w_ctrl_idle && ({1'b0, script_idx} < c_DEPTH)) begin
            r_mem_kind[script_idx] <= script_kind;
            r_mem_addr[script_idx] <= script_addr;
            r_mem_data[script_idx] <= script_data;
            r_mem_mask[script_idx] <= script_mask;
        end
    end

    // Sequencer FSM with registered DMI, status and exit outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                 <= S_IDLE;
            r_index                 <= '0;
            r_retry                 <= '0;
            r_poll                  <= '0;
            r_timeout               <= '0;
            dmi.debug_req_valid     <= 1'b0;
            dmi.debug_req_bits_addr <= '0;
            dmi.debug_req_bits_op   <= 2'd0;
            dmi.debug_req_bits_data <= '0;
            dmi.debug_resp_ready    <= 1'b0;
            busy                    <= 1'b0;
            rd_valid                <= 1'b0;
            rd_data                 <= '0;
            exit                    <= 32'd0;
        end else begin
            rd_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_index   <= '0;
                        r_retry   <= '0;
                        r_poll    <= '0;
                        r_timeout <= '0;
                        exit      <= 32'd0;
                        if (w_ld_kind == c_KIND_END) begin
                            r_state <= S_DONE;
                            exit    <= 32'd1;
                        end else begin
                            r_state                 <= S_ISSUE;
                            busy                    <= 1'b1;
                            dmi.debug_req_valid     <= 1'b1;
                            dmi.debug_req_bits_addr <= w_ld_addr;
                            dmi.debug_req_bits_op   <= w_ld_op;
                            dmi.debug_req_bits_data <= w_ld_wdata;
                        end
                    end
                end

                S_ISSUE: begin
                    if (w_req_fire) begin
                        r_state              <= S_WAIT_RESP;
                        r_timeout            <= '0;
                        dmi.debug_req_valid  <= 1'b0;
                        dmi.debug_resp_ready <= 1'b1;
                    end else if (w_tmo_expired) begin
                        r_state             <= S_DONE;
                        busy                <= 1'b0;
                        dmi.debug_req_valid <= 1'b0;
                        exit                <= f_exit_fail(c_FAIL_TIMEOUT);
                    end else begin
                        r_timeout <= r_timeout + c_TMO_W'(1);
                    end
                end

                S_WAIT_RESP: begin
                    if (w_resp_fire) begin
                        r_timeout            <= '0;
                        dmi.debug_resp_ready <= 1'b0;
                        if (dmi.debug_resp_bits_resp == c_RESP_BUSY) begin
                            if (w_retry_inc > c_MAX_RETRY) begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                exit    <= f_exit_fail(c_FAIL_RETRY);
                            end else begin
                                // Request fields are still held, so reissue is just valid.
                                r_retry             <= w_retry_inc;
                                r_state             <= S_ISSUE;
                                dmi.debug_req_valid <= 1'b1;
                            end
                        end else if (dmi.debug_resp_bits_resp != c_RESP_OK) begin
                            // The reserved code 1 is treated like an explicit failure.
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            exit    <= f_exit_fail(c_FAIL_RESP);
                        end else begin
                            if (w_cur_kind != c_KIND_WRITE) begin
                                rd_data  <= dmi.debug_resp_bits_data;
                                rd_valid <= 1'b1;
                            end
                            if (w_poll_miss) begin
                                if (w_poll_inc > c_MAX_POLL) begin
                                    r_state <= S_DONE;
                                    busy    <= 1'b0;
                                    exit    <= f_exit_fail(c_FAIL_POLL);
                                end else begin
                                    r_poll              <= w_poll_inc;
                                    r_state             <= S_ISSUE;
                                    dmi.debug_req_valid <= 1'b1;
                                end
                            end else if (w_last_slot || (w_ld_kind == c_KIND_END)) begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                exit    <= 32'd1;
                            end else begin
                                r_index                 <= w_next_index;
                                r_retry                 <= '0;
                                r_poll                  <= '0;
                                r_state                 <= S_ISSUE;
                                dmi.debug_req_valid     <= 1'b1;
                                dmi.debug_req_bits_addr <= w_ld_addr;
                                dmi.debug_req_bits_op   <= w_ld_op;
                                dmi.debug_req_bits_data <= w_ld_wdata;
                            end
                        end
                    end else if (w_tmo_expired) begin
                        r_state              <= S_DONE;
                        busy                 <= 1'b0;
                        dmi.debug_resp_ready <= 1'b0;
                        exit                 <= f_exit_fail(c_FAIL_TIMEOUT);
                    end else begin
                        r_timeout <= r_timeout + c_TMO_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sim_dmi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_dmi_sequencer
//  Description : Scoreboard bench for sim_dmi_sequencer with a scripted DMI
//                responder; expected requests, read data and exit codes are
//                queued by the stimulus and checked by a separate monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_dmi_sequencer;
    localparam int ADDR_WIDTH     = 7;
    localparam int DATA_WIDTH     = 32;
    localparam int SCRIPT_DEPTH   = 4;
    localparam int MAX_RETRIES    = 8;
    localparam int MAX_POLLS      = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int IDXW           = 2;

    localparam logic [1:0] K_WRITE = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_POLL  = 2'd2;
    localparam logic [1:0] K_END   = 2'd3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  busy;
    logic                  script_we = 1'b0;
    logic [IDXW-1:0]       script_idx = '0;
    logic [1:0]            script_kind = '0;
    logic [ADDR_WIDTH-1:0] script_addr = '0;
    logic [DATA_WIDTH-1:0] script_data = '0;
    logic [DATA_WIDTH-1:0] script_mask = '0;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [31:0]           exit;

    sim_dmi_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dmi();

    sim_dmi_sequencer #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .SCRIPT_DEPTH  (SCRIPT_DEPTH),
        .MAX_RETRIES   (MAX_RETRIES),
        .MAX_POLLS     (MAX_POLLS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .script_we  (script_we),
        .script_idx (script_idx),
        .script_kind(script_kind),
        .script_addr(script_addr),
        .script_data(script_data),
        .script_mask(script_mask),
        .dmi        (dmi),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .exit       (exit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_req_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_exit_q[$];
    logic [33:0] rsp_q[$];

    logic        hs_req = 1'b0;
    logic        hs_resp = 1'b0;
    logic        ready_en = 1'b1;
    int          resp_delay = 0;
    logic [31:0] prev_exit = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rq(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        rq = {23'd0, a, op, d};
    endfunction

    // Handshake flags as seen just before the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            hs_req  = dmi.debug_req_valid && dmi.debug_req_ready;
            hs_resp = dmi.debug_resp_valid && dmi.debug_resp_ready;
        end
    end

    // Responder: answers each accepted request after resp_delay cycles.
    initial begin : p_responder
        logic [33:0] r;
        bit          pend;
        int          pend_cnt;
        pend = 0;
        pend_cnt = 0;
        dmi.debug_req_ready      = 1'b0;
        dmi.debug_resp_valid     = 1'b0;
        dmi.debug_resp_bits_resp = 2'd0;
        dmi.debug_resp_bits_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pend = 0;
                dmi.debug_resp_valid = 1'b0;
            end else begin
                if (hs_resp) dmi.debug_resp_valid = 1'b0;
                if (hs_req) begin
                    pend = 1;
                    pend_cnt = resp_delay;
                end
                if (pend && pend_cnt == 0) begin
                    r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 34'd0;
                    dmi.debug_resp_bits_resp = r[33:32];
                    dmi.debug_resp_bits_data = r[31:0];
                    dmi.debug_resp_valid = 1'b1;
                    pend = 0;
                end else if (pend) begin
                    pend_cnt--;
                end
            end
            dmi.debug_req_ready = ready_en;
        end
    end

    // Monitor: compares every DUT-presented event against the scoreboard.
    initial begin : p_monitor
        logic [63:0] e;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dmi.debug_req_valid && dmi.debug_req_ready) begin
                    checks++;
                    if (exp_req_q.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected actual=0x%0h required=none",
                                 rq(dmi.debug_req_bits_addr, dmi.debug_req_bits_op, dmi.debug_req_bits_data));
                    end else begin
                        checks--;
                        e = exp_req_q.pop_front();
                        chk("req_fields", rq(dmi.debug_req_bits_addr, dmi.debug_req_bits_op,
                                            dmi.debug_req_bits_data), e);
                    end
                end
                if (rd_valid) begin
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_unexpected actual=0x%0h required=none", rd_data);
                    end else begin
                        checks--;
                        d = exp_rd_q.pop_front();
                        chk("rd_data", 64'(rd_data), 64'(d));
                    end
                end
                if (exit != 32'd0 && prev_exit == 32'd0) begin
                    checks++;
                    if (exp_exit_q.size() == 0) begin
                        errors++;
                        $display("FAIL exit_unexpected actual=0x%0h required=none", exit);
                    end else begin
                        checks--;
                        d = exp_exit_q.pop_front();
                        chk("exit_code", 64'(exit), 64'(d));
                    end
                end
            end
            prev_exit = exit;
        end
    end

    task automatic load(input int idx, input logic [1:0] kind, input logic [6:0] addr,
                        input logic [31:0] data, input logic [31:0] mask);
        @(posedge clk);
        #1;
        script_we   = 1'b1;
        script_idx  = idx[1:0];
        script_kind = kind;
        script_addr = addr;
        script_data = data;
        script_mask = mask;
        @(posedge clk);
        #1;
        script_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Starts the script, waits for exit, checks latency and drained queues.
    task automatic run(input string name, input int exp_lat);
        int lat;
        bit done;
        pulse_start();
        lat = 0;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (exit != 32'd0 && !busy) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout actual=busy required=done", name);
        end else if (exp_lat > 0) begin
            chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        end
        repeat (3) @(negedge clk);
        chk({name, "_req_left"}, 64'(exp_req_q.size()), 64'd0);
        chk({name, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
        chk({name, "_exit_left"}, 64'(exp_exit_q.size()), 64'd0);
        exp_req_q.delete();
        exp_rd_q.delete();
        exp_exit_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(dmi.debug_req_valid), 64'd0);
        chk("rst_resp_ready", 64'(dmi.debug_resp_ready), 64'd0);
        chk("rst_exit", 64'(exit), 64'd0);
        chk("rst_rd", 64'({rd_valid, rd_data}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single write then END, zero-wait responder.
        load(0, K_WRITE, 7'h10, 32'h1, 32'h0);
        load(1, K_END, 7'h00, 32'h0, 32'h0);
        exp_req_q.push_back(rq(7'h10, 2'd2, 32'h1));
        exp_exit_q.push_back(32'd1);
        run("write", 3);

        // Read returning data.
        load(0, K_READ, 7'h11, 32'h0, 32'h0);
        rsp_q.push_back({2'd0, 32'hDEADBEEF});
        exp_req_q.push_back(rq(7'h11, 2'd1, 32'h0));
        exp_rd_q.push_back(32'hDEADBEEF);
        exp_exit_q.push_back(32'd1);
        run("read", 3);

        // Write answered busy three times, then ok.
        load(0, K_WRITE, 7'h20, 32'hA5, 32'h0);
        for (int i = 0; i < 3; i++) rsp_q.push_back({2'd3, 32'h0});
        rsp_q.push_back({2'd0, 32'h0});
        for (int i = 0; i < 4; i++) exp_req_q.push_back(rq(7'h20, 2'd2, 32'hA5));
        exp_exit_q.push_back(32'd1);
        run("retry_pass", 9);

        // Eight busy responses are still tolerated.
        for (int i = 0; i < 8; i++) rsp_q.push_back({2'd3, 32'h0});
        for (int i = 0; i < 9; i++) exp_req_q.push_back(rq(7'h20, 2'd2, 32'hA5));
        exp_exit_q.push_back(32'd1);
        run("retry_max", 19);

        // Nine busy responses exceed the retry budget.
        for (int i = 0; i < 9; i++) rsp_q.push_back({2'd3, 32'h0});
        for (int i = 0; i < 9; i++) exp_req_q.push_back(rq(7'h20, 2'd2, 32'hA5));
        exp_exit_q.push_back(32'd5);
        run("retry_fail", 19);

        // Poll: two masked mismatches then a masked match.
        load(0, K_POLL, 7'h04, 32'h100, 32'h100);
        rsp_q.push_back({2'd0, 32'h0});
        rsp_q.push_back({2'd0, 32'h0FF});
        rsp_q.push_back({2'd0, 32'h1100});
        for (int i = 0; i < 3; i++) exp_req_q.push_back(rq(7'h04, 2'd1, 32'h0));
        exp_rd_q.push_back(32'h0);
        exp_rd_q.push_back(32'h0FF);
        exp_rd_q.push_back(32'h1100);
        exp_exit_q.push_back(32'd1);
        run("poll_pass", 7);

        // Poll: three mismatches exceed MAX_POLLS=2.
        rsp_q.push_back({2'd0, 32'h0});
        rsp_q.push_back({2'd0, 32'h200});
        rsp_q.push_back({2'd0, 32'h0});
        for (int i = 0; i < 3; i++) exp_req_q.push_back(rq(7'h04, 2'd1, 32'h0));
        exp_rd_q.push_back(32'h0);
        exp_rd_q.push_back(32'h200);
        exp_rd_q.push_back(32'h0);
        exp_exit_q.push_back(32'd11);
        run("poll_fail", 7);

        // Failed response.
        load(0, K_WRITE, 7'h05, 32'hCAFE, 32'h0);
        rsp_q.push_back({2'd2, 32'h0});
        exp_req_q.push_back(rq(7'h05, 2'd2, 32'hCAFE));
        exp_exit_q.push_back(32'd7);
        run("resp_failed", 3);

        // Full table without END: implicit end after the last slot.
        load(0, K_WRITE, 7'h01, 32'h11, 32'h0);
        load(1, K_READ, 7'h02, 32'h0, 32'h0);
        load(2, K_WRITE, 7'h03, 32'h33, 32'h0);
        load(3, K_WRITE, 7'h04, 32'h44, 32'h0);
        rsp_q.push_back({2'd0, 32'h0});
        rsp_q.push_back({2'd0, 32'h12345678});
        rsp_q.push_back({2'd0, 32'h0});
        rsp_q.push_back({2'd0, 32'h0});
        exp_req_q.push_back(rq(7'h01, 2'd2, 32'h11));
        exp_req_q.push_back(rq(7'h02, 2'd1, 32'h0));
        exp_req_q.push_back(rq(7'h03, 2'd2, 32'h33));
        exp_req_q.push_back(rq(7'h04, 2'd2, 32'h44));
        exp_rd_q.push_back(32'h12345678);
        exp_exit_q.push_back(32'd1);
        run("implicit_end", 9);

        // Request never accepted: timeout after 16 cycles of valid.
        ready_en = 1'b0;
        load(0, K_WRITE, 7'h06, 32'h1, 32'h0);
        load(1, K_END, 7'h00, 32'h0, 32'h0);
        exp_exit_q.push_back(32'd9);
        run("timeout", 17);
        chk("timeout_valid_low", 64'(dmi.debug_req_valid), 64'd0);
        chk("timeout_busy_low", 64'(busy), 64'd0);
        ready_en = 1'b1;

        // Asynchronous reset while waiting for a response.
        load(0, K_WRITE, 7'h33, 32'h77, 32'h0);
        resp_delay = 5;
        exp_req_q.push_back(rq(7'h33, 2'd2, 32'h77));
        pulse_start();
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (dmi.debug_resp_ready) ok = 1;
        end
        chk("arst_reached_wait", 64'(ok), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_resp_ready", 64'(dmi.debug_resp_ready), 64'd0);
        chk("arst_req", rq(dmi.debug_req_bits_addr, dmi.debug_req_bits_op, dmi.debug_req_bits_data), 64'd0);
        chk("arst_valid", 64'(dmi.debug_req_valid), 64'd0);
        chk("arst_rd", 64'({rd_valid, rd_data}), 64'd0);
        chk("arst_exit", 64'(exit), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        resp_delay = 0;
        rsp_q.delete();
        chk("arst_req_left", 64'(exp_req_q.size()), 64'd0);
        exp_req_q.delete();
        exp_req_q.push_back(rq(7'h33, 2'd2, 32'h77));
        exp_exit_q.push_back(32'd1);
        run("rerun", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
